fb_pixel_writer: RTL and testbench

Accepts the rasterizer's pixel stream one pixel per handshake, clips it to the screen, converts (x, y) to a linear framebuffer address and writes packed 24-bit RGB into framebuffer memory through a write port with back-pressure. A small FIFO decouples the rasterizer from memory stalls. A full-screen clear sequencer fills the framebuffer with a constant colour between frames. It sits between the rasterization stage and the framebuffer memory.

---
 rtl/fb_pixel_writer_if.sv | 29 ++
 rtl/fb_pixel_writer.sv | 203 ++++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pixel_writer_if.sv
// Bus interfaces for fb_pixel_writer.
//   fb_pixel_if : rasterizer pixel stream (master = rasterizer, slave = writer)
//   fb_mem_if   : framebuffer write port  (master = writer, slave = memory)
interface fb_pixel_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_x;
  logic [8:0] in_y;
  logic [7:0] in_red;
  logic [7:0] in_green;
  logic [7:0] in_blue;

  modport master (output in_valid, in_x, in_y, in_red, in_green, in_blue,
                  input  in_ready);
  modport slave  (input  in_valid, in_x, in_y, in_red, in_green, in_blue,
                  output in_ready);
endinterface

interface fb_mem_if #(
  parameter int ADDR_W = 19
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, mem_addr, mem_wdata, input  mem_ready);
  modport slave  (input  mem_we, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips rasterizer pixels to the screen, converts (x, y) to a
// linear framebuffer address and writes packed RGB through a back-pressured
// write port, buffered by a small FIFO. A clear sequencer fills the whole
// framebuffer with a constant colour after draining pending pixels.
// Optional feature macro: FB_WRITER_CLIP_EN (bounds check + dropped_count).
module fb_pixel_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_W        = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  fb_pixel_if.slave   pix,
  fb_mem_if.master    mem,
  input  logic        clear_start,
  input  logic [23:0] clear_color,
  output logic        busy,
  output logic [15:0] dropped_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      WIDTH_U = 32'(SCREEN_WIDTH);
  localparam logic [31:0]      TOTAL_U = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_0   = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Linear address y*W + x, computed at 32 bits then truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [8:0] y);
    logic [31:0] full;
    full = 32'(y) * WIDTH_U + 32'(x);
    return ADDR_W'(full);
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic              ready_en_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              in_range_s;
  logic              push_s;
  logic              pop_s;
  logic              load_s;
  logic              drained_s;
  logic              clear_done_s;

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [23:0]       fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [23:0]       mem_wdata_r;
  logic [31:0]       clr_addr_r;
  logic [23:0]       clr_color_r;

  // Handshake, FIFO push/pop and sequencing qualifiers.
  always_comb begin
    in_ready_s = ready_en_r && (state_r == ST_RUN) && (count_r < DEPTH_C);
    accept_s   = pix.in_valid && in_ready_s;
`ifdef FB_WRITER_CLIP_EN
    in_range_s = (32'(pix.in_x) < WIDTH_U) && (32'(pix.in_y) < 32'(SCREEN_HEIGHT));
`else
    in_range_s = 1'b1;
`endif
    push_s       = accept_s && in_range_s;
    load_s       = !mem_we_r || mem.mem_ready;
    pop_s        = load_s && (state_r != ST_CLEAR) && (count_r != CNT_0);
    drained_s    = (count_r == CNT_0) && !mem_we_r;
    clear_done_s = (state_r == ST_CLEAR) && (clr_addr_r == TOTAL_U) && load_s;
  end

  assign pix.in_ready  = in_ready_s;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign busy          = (count_r != CNT_0) || mem_we_r || (state_r != ST_RUN);

  // Holds in_ready low during reset and enables it from the first cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_r <= 1'b0;
    else        ready_en_r <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_RUN;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state: a clear waits for every queued pixel to be written first.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN:   if (clear_start)  state_nxt_s = ST_DRAIN; else state_nxt_s = ST_RUN;
      ST_DRAIN: if (drained_s)    state_nxt_s = ST_CLEAR; else state_nxt_s = ST_DRAIN;
      ST_CLEAR: if (clear_done_s) state_nxt_s = ST_RUN;   else state_nxt_s = ST_CLEAR;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // Pixel FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_data_r[i] <= 24'h0;
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= lin_addr(pix.in_x, pix.in_y);
        fifo_data_r[wr_ptr_r] <= {pix.in_red, pix.in_green, pix.in_blue};
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write-port register: refills from the FIFO head or the clear sequencer
  // whenever the slot is empty or its write completes; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 24'h0;
    end else if (load_s) begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_addr_r < TOTAL_U) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= clr_addr_r[ADDR_W-1:0];
            mem_wdata_r <= clr_color_r;
          end else begin
            mem_we_r <= 1'b0;
          end
        end
        default: begin
          if (count_r != CNT_0) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= fifo_addr_r[rd_ptr_r];
            mem_wdata_r <= fifo_data_r[rd_ptr_r];
          end else begin
            mem_we_r <= 1'b0;
          end
        end
      endcase
    end
  end

  // Clear sequencer: latches the colour and walks addresses 0..W*H-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_r  <= 32'h0;
      clr_color_r <= 24'h0;
    end else begin
      if ((state_r == ST_RUN) && clear_start) begin
        clr_color_r <= clear_color;
      end
      if ((state_r == ST_DRAIN) && drained_s) begin
        clr_addr_r <= 32'h0;
      end else if ((state_r == ST_CLEAR) && load_s && (clr_addr_r < TOTAL_U)) begin
        clr_addr_r <= clr_addr_r + 32'h1;
      end
    end
  end

`ifdef FB_WRITER_CLIP_EN
  logic [15:0] dropped_r;

  // Saturating count of pixels consumed but discarded by the clip test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_r <= 16'h0;
    end else if (accept_s && !in_range_s && (dropped_r != 16'hFFFF)) begin
      dropped_r <= dropped_r + 16'h1;
    end
  end

  assign dropped_count = dropped_r;
`else
  assign dropped_count = 16'h0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer on a reduced 40x30 screen.
module tb_fb_pixel_writer;
  localparam int W     = 40;
  localparam int H     = 30;
  localparam int D     = 4;
  localparam int AW    = 19;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_start = 1'b0;
  logic [23:0] clear_color = 24'h0;
  logic        busy;
  logic [15:0] dropped_count;
  logic        man_ready = 1'b0;
  logic        auto_ready = 1'b0;
  logic        rnd_ready = 1'b1;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  logic [AW-1:0] log_addr [$];
  logic [23:0]   log_data [$];
  int            log_cyc  [$];

  fb_pixel_if pix ();
  fb_mem_if #(.ADDR_W(AW)) mem ();

  assign mem.mem_ready = auto_ready ? rnd_ready : man_ready;

  fb_pixel_writer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FIFO_DEPTH(D), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix(pix), .mem(mem),
    .clear_start(clear_start), .clear_color(clear_color),
    .busy(busy), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 2) != 0);
  end

  // Write log: every completed write (mem_we && mem_ready before the next edge).
  always @(negedge clk) begin
    #2;
    if (mem.mem_we && mem.mem_ready) begin
      log_addr.push_back(mem.mem_addr);
      log_data.push_back(mem.mem_wdata);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Presents one pixel and returns at the negedge after it was accepted.
  task automatic send_pixel(input logic [9:0] x, input logic [8:0] y, input logic [23:0] rgb);
    int n;
    n = 0;
    pix.in_x = x; pix.in_y = y;
    {pix.in_red, pix.in_green, pix.in_blue} = rgb;
    pix.in_valid = 1'b1;
    #1;
    while (!pix.in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL send_timeout: pixel (%0d,%0d) not accepted in %0d cycles", x, y, n);
    end
    @(negedge clk);
    pix.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    pix.in_valid = 1'b0; pix.in_x = 10'd0; pix.in_y = 9'd0;
    pix.in_red = 8'd0; pix.in_green = 8'd0; pix.in_blue = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pix.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", pix.in_ready); end
    checks++; if (mem.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem.mem_we); end
    checks++; if (mem.mem_addr !== 19'd0) begin failures++; $display("FAIL reset_mem_addr: got %0d want 0", mem.mem_addr); end
    checks++; if (mem.mem_wdata !== 24'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem.mem_wdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (pix.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", pix.in_ready); end
  endtask

  task automatic test_single();
    int base;
    @(negedge clk);
    man_ready = 1'b1;
    base = log_addr.size();
    pix.in_x = 10'd3; pix.in_y = 9'd2;
    pix.in_red = 8'h11; pix.in_green = 8'h22; pix.in_blue = 8'h33;
    pix.in_valid = 1'b1;
    #1;
    checks++; if (pix.in_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", pix.in_ready); end
    @(negedge clk);
    pix.in_valid = 1'b0;
    #1;
    checks++; if (mem.mem_we !== 1'b0) begin failures++; $display("FAIL single_early_we: got %b want 0", mem.mem_we); end
    @(negedge clk); #1;
    checks++; if (mem.mem_we !== 1'b1) begin failures++; $display("FAIL single_we: got %b want 1", mem.mem_we); end
    checks++; if (mem.mem_addr !== 19'd83) begin failures++; $display("FAIL single_addr: got %0d want 83", mem.mem_addr); end
    checks++; if (mem.mem_wdata !== 24'h112233) begin failures++; $display("FAIL single_data: got %h want 112233", mem.mem_wdata); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done: got %b want 0", busy); end
    checks++; if (log_addr.size() != base + 1) begin failures++; $display("FAIL single_count: got %0d want %0d", log_addr.size() - base, 1); end
  endtask

  task automatic test_backpressure();
    int base, n, bad;
    @(negedge clk);
    man_ready = 1'b0;
    base = log_addr.size();
    for (int i = 0; i < 5; i++) send_pixel(10'(i + 5), 9'(i), {8'(i), 8'(i + 16), 8'(i + 32)});
    pix.in_x = 10'd10; pix.in_y = 9'd5;
    pix.in_red = 8'd5; pix.in_green = 8'd21; pix.in_blue = 8'd37;
    pix.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pix.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", pix.in_ready); end
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_addr !== 19'd5) begin failures++; $display("FAIL bp_head: got we=%b addr=%0d want we=1 addr=5", mem.mem_we, mem.mem_addr); end
    checks++; if (log_addr.size() != base) begin failures++; $display("FAIL bp_no_write: got %0d writes want 0", log_addr.size() - base); end
    man_ready = 1'b1;
    n = 0;
    while (!pix.in_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    pix.in_valid = 1'b0;
    n = 0;
    #1;
    while (busy && n < 50) begin @(negedge clk); #1; n++; end
    checks++; if (log_addr.size() != base + 6) begin failures++; $display("FAIL bp_count: got %0d want 6", log_addr.size() - base); end
    bad = 0;
    for (int i = 0; i < 6 && base + i < log_addr.size(); i++) begin
      if (log_addr[base + i] !== 19'(41 * i + 5) || log_data[base + i] !== {8'(i), 8'(i + 16), 8'(i + 32)}) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_order: got %0d bad entries want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int base, c0, bad, n;
    @(negedge clk);
    man_ready = 1'b1;
    base = log_addr.size();
    c0 = cyc;
    for (int i = 0; i < 4; i++) send_pixel(10'(i), 9'd7, 24'(i + 100));
    checks++; if (cyc - c0 != 4) begin failures++; $display("FAIL b2b_accept_cycles: got %0d want 4", cyc - c0); end
    n = 0;
    #1;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (log_addr.size() != base + 4) begin failures++; $display("FAIL b2b_count: got %0d want 4", log_addr.size() - base); end
    bad = 0;
    for (int i = 1; i < 4 && base + i < log_addr.size(); i++) begin
      if (log_cyc[base + i] - log_cyc[base + i - 1] != 1 || log_addr[base + i] !== 19'(280 + i)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_rate: got %0d gaps/bad want 0", bad); end
  endtask

  task automatic test_clip();
    int base;
    @(negedge clk);
    man_ready = 1'b1;
    base = log_addr.size();
    send_pixel(10'd40, 9'd0, 24'h010203);
    send_pixel(10'd0, 9'd30, 24'h040506);
    send_pixel(10'd39, 9'd29, 24'h070809);
    repeat (4) @(negedge clk);
    #1;
`ifdef FB_WRITER_CLIP_EN
    checks++; if (dropped_count !== 16'd2) begin failures++; $display("FAIL clip_dropped: got %0d want 2", dropped_count); end
    checks++; if (log_addr.size() != base + 1) begin failures++; $display("FAIL clip_count: got %0d want 1", log_addr.size() - base); end
    checks++; if (log_addr.size() > base && log_addr[base] !== 19'd1199) begin failures++; $display("FAIL clip_edge_addr: got %0d want 1199", log_addr[base]); end
`else
    checks++; if (dropped_count !== 16'd0) begin failures++; $display("FAIL noclip_dropped: got %0d want 0", dropped_count); end
    checks++; if (log_addr.size() != base + 3) begin failures++; $display("FAIL noclip_count: got %0d want 3", log_addr.size() - base); end
    checks++; if (log_addr.size() >= base + 3 && (log_addr[base] !== 19'd40 || log_addr[base + 1] !== 19'd1200 || log_addr[base + 2] !== 19'd1199))
      begin failures++; $display("FAIL noclip_addr: got %0d %0d %0d want 40 1200 1199", log_addr[base], log_addr[base + 1], log_addr[base + 2]); end
`endif
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clip_busy: got %b want 0", busy); end
  endtask

  task automatic test_clear();
    int base, n, rbad, bad;
    @(negedge clk);
    man_ready = 1'b0;
    base = log_addr.size();
    send_pixel(10'd1, 9'd0, 24'h0A0B0C);
    send_pixel(10'd2, 9'd0, 24'h0D0E0F);
    clear_color = 24'hABCDEF;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    clear_color = 24'h0;
    #1;
    checks++; if (pix.in_ready !== 1'b0) begin failures++; $display("FAIL clear_ready_drop: got %b want 0", pix.in_ready); end
    man_ready = 1'b1;
    rbad = 0;
    for (n = 1; n <= TOTAL + 100; n++) begin
      @(negedge clk); #1;
      if (!busy) break;
      if (pix.in_ready !== 1'b0) rbad++;
    end
    checks++; if (n > TOTAL + 10) begin failures++; $display("FAIL clear_duration: got %0d cycles want <= %0d", n, TOTAL + 10); end
    checks++; if (rbad != 0) begin failures++; $display("FAIL clear_ready_hold: got %0d cycles ready=1 want 0", rbad); end
    checks++; if (pix.in_ready !== 1'b1) begin failures++; $display("FAIL clear_ready_back: got %b want 1", pix.in_ready); end
    checks++; if (log_addr.size() != base + 2 + TOTAL) begin failures++; $display("FAIL clear_count: got %0d want %0d", log_addr.size() - base, TOTAL + 2); end
    checks++; if (log_addr.size() >= base + 2 && (log_addr[base] !== 19'd1 || log_addr[base + 1] !== 19'd2))
      begin failures++; $display("FAIL clear_pixels_first: got %0d %0d want 1 2", log_addr[base], log_addr[base + 1]); end
    bad = 0;
    for (int k = 0; k < TOTAL && base + 2 + k < log_addr.size(); k++)
      if (log_addr[base + 2 + k] !== 19'(k) || log_data[base + 2 + k] !== 24'hABCDEF) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL clear_fill: got %0d bad entries want 0", bad); end
  endtask

  task automatic test_clear_stall();
    int base, n, bad, stalls;
    logic prev_stall;
    logic [AW-1:0] s_addr;
    logic [23:0] s_data;
    @(negedge clk);
    auto_ready = 1'b1;
    base = log_addr.size();
    clear_color = 24'h123456;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    prev_stall = 1'b0; stalls = 0; bad = 0;
    s_addr = '0; s_data = 24'h0;
    for (n = 0; n < 6 * TOTAL; n++) begin
      @(negedge clk); #1;
      if (prev_stall) begin
        checks++;
        if (mem.mem_addr !== s_addr || mem.mem_wdata !== s_data) begin
          failures++;
          $display("FAIL stall_hold: got %0d/%h want %0d/%h", mem.mem_addr, mem.mem_wdata, s_addr, s_data);
        end
      end
      prev_stall = mem.mem_we && !mem.mem_ready;
      if (prev_stall) begin stalls++; s_addr = mem.mem_addr; s_data = mem.mem_wdata; end
      if (!busy) break;
    end
    auto_ready = 1'b0;
    man_ready = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_timeout: busy=%b after %0d cycles want 0", busy, n); end
    checks++; if (stalls == 0) begin failures++; $display("FAIL stall_seen: got 0 stall cycles want >0"); end
    checks++; if (log_addr.size() != base + TOTAL) begin failures++; $display("FAIL stall_count: got %0d want %0d", log_addr.size() - base, TOTAL); end
    for (int k = 0; k < TOTAL && base + k < log_addr.size(); k++)
      if (log_addr[base + k] !== 19'(k) || log_data[base + k] !== 24'h123456) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_seq: got %0d bad entries want 0", bad); end
  endtask

  task automatic test_reset_mid_clear();
    int base, n;
    @(negedge clk);
    man_ready = 1'b1;
    clear_color = 24'h00FF00;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (n = 0; n < TOTAL + 50; n++) begin
      @(negedge clk); #1;
      if (mem.mem_we && mem.mem_addr == 19'd1000) break;
    end
    checks++; if (n >= TOTAL + 50) begin failures++; $display("FAIL rstclr_reach: address 1000 not reached in %0d cycles", n); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem.mem_we !== 1'b0 || mem.mem_addr !== 19'd0 || mem.mem_wdata !== 24'h0)
      begin failures++; $display("FAIL rstclr_outputs: got we=%b addr=%0d data=%h want 0/0/0", mem.mem_we, mem.mem_addr, mem.mem_wdata); end
    checks++; if (busy !== 1'b0 || pix.in_ready !== 1'b0 || dropped_count !== 16'd0)
      begin failures++; $display("FAIL rstclr_status: got busy=%b ready=%b dropped=%0d want 0/0/0", busy, pix.in_ready, dropped_count); end
    @(negedge clk);
    rst_n = 1'b1;
    base = log_addr.size();
    @(negedge clk); #1;
    checks++; if (pix.in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstclr_run: got ready=%b busy=%b want 1/0", pix.in_ready, busy); end
    repeat (3) @(negedge clk);
    checks++; if (log_addr.size() != base) begin failures++; $display("FAIL rstclr_no_resume: got %0d writes want 0", log_addr.size() - base); end
    send_pixel(10'd3, 9'd2, 24'h445566);
    repeat (3) @(negedge clk);
    checks++; if (log_addr.size() != base + 1 || (log_addr.size() > base && log_addr[base] !== 19'd83))
      begin failures++; $display("FAIL rstclr_pixel: got %0d writes want 1 at addr 83", log_addr.size() - base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_clip();
    test_clear();
    test_clear_stall();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
